rx_block_packer: RTL and testbench
==================================

# rx_block_packer

Downstream of the CipherCore UART receiver, running in the 30 MHz core clock domain. Collects received bytes, MSB-first, into fixed-width cipher blocks and presents each completed block to the cipher datapath over a valid/ready handshake. Discards malformed bytes and partial blocks on framing errors. Flags bytes lost while a block is stalled.

## Interface
- `BLOCK_BYTES`, default 8: bytes per block. Legal values are 2 to 16.
- `TIMEOUT_CYCLES`, default 300000: inter-byte timeout in clock cycles (10 ms at 30 MHz). Used only when the timeout is compiled in.
- `clk`, input, 1: core clock (30 MHz).
- `rst_n`, input, 1: asynchronous active-low reset.
- `rx_data`, input, 8: received byte. Sampled only when `done` is high.
- `done`, input, 1: one-cycle strobe marking the end of a received frame.
- `valid`, input, 1: frame-good qualifier, sampled with `done`. High means the stop bit and parity were good.
- `blk_data`, output, 8*BLOCK_BYTES: assembled block. The first received byte sits in the top byte.
- `blk_valid`, output, 1: a block is available.
- `blk_ready`, input, 1: the consumer accepts the block.
- `byte_cnt`, output, $clog2(BLOCK_BYTES+1): number of bytes collected so far.
- `err`, output, 1: one-cycle pulse when a partial block is discarded because of a bad frame or a timeout.
- `overrun`, output, 1: one-cycle pulse when a good byte is dropped because the block is held.

## Operation
- The block has three states: IDLE, COLLECT and HOLD.
- A byte is accepted on any cycle where `done` and `valid` are both high and the block is not stalled.
- On acceptance, the shift register shifts left by 8 and `rx_data` enters the bottom byte. `byte_cnt` increments.
- IDLE:
  - An accepted byte moves the block to COLLECT with `byte_cnt` = 1.
  - With `BLOCK_BYTES` = 1 the block would move straight to HOLD, but that value is illegal.
- COLLECT:
  - When the accepted byte brings `byte_cnt` to `BLOCK_BYTES`, the block moves to HOLD and `blk_valid` = 1.
  - `done` with `valid` = 0 discards the partial block: `byte_cnt` goes to 0, `err` pulses, and the state returns to IDLE.
- HOLD:
  - `blk_data` and `blk_valid` stay stable until `blk_valid` and `blk_ready` are both high.
  - On the handshake, `blk_valid` drops, `byte_cnt` goes to 0, and the state returns to IDLE.
  - A `done` arriving in HOLD with no handshake that cycle drops the byte. If `valid` = 1, `overrun` pulses. If `valid` = 0 the byte is ignored silently, with no `err`.
  - If `done`/`valid` arrives in the same cycle as the handshake, the byte is accepted as byte 0 of the next block and the state goes to COLLECT with `byte_cnt` = 1. There is no bubble.
- `blk_ready` is ignored outside HOLD.
- `blk_data` always reflects the shift register. Its contents are defined only while `blk_valid` is high.

## Timing
- Reset values: state IDLE, `blk_data` = 0, `blk_valid` = 0, `byte_cnt` = 0, `err` = 0, `overrun` = 0. The timeout counter resets to 0.
- Reset is asynchronous. Asserting it mid-block or in HOLD drops all data immediately.
- `blk_valid` rises on the clock edge that captures the final byte, so latency from the last `done` is 1 cycle.
- `blk_valid` falls on the clock edge after the handshake cycle.
- Back-to-back `done` strobes on consecutive cycles are each accepted.
- `err` and `overrun` are registered and last exactly one cycle each.
- All outputs are registered. There is no combinational path from `blk_ready` or `done` to any output.

## Configuration
- `PACKER_TIMEOUT_EN` defined:
  - A counter runs while in COLLECT. It clears on every accepted byte.
  - When the counter reaches `TIMEOUT_CYCLES` − 1, the partial block is discarded: `byte_cnt` goes to 0, `err` pulses, and the state returns to IDLE.
  - If an accepted byte arrives in the same cycle as the expiry, the byte wins and the timeout does not fire.
  - The counter holds at 0 in IDLE and in HOLD.
- `PACKER_TIMEOUT_EN` undefined: there is no counter, and a partial block waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Test plan
- Normal block: send 8 good bytes 0x01…0x08 with `blk_ready` = 1. Expect `blk_valid` for 1 cycle with `blk_data` = 0x0102030405060708, then `byte_cnt` = 0.
- Stall: hold `blk_ready` = 0 after a full block, then send byte 0xAA. Expect `overrun` to pulse once and `blk_data` to stay unchanged. After `blk_ready` = 1, expect `byte_cnt` = 0.
- Handshake plus byte in the same cycle: a full block is held, and `blk_ready` = 1 arrives with `done`/`valid` carrying 0x55. Expect `blk_valid` = 0 next cycle, `byte_cnt` = 1, and 0x55 in the bottom byte.
- Bad frame: send 3 good bytes, then `done` with `valid` = 0. Expect `err` to pulse and `byte_cnt` = 0. Then send 8 good bytes and expect a correct block.
- Timeout (`PACKER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16): send 2 bytes, then idle. Expect `err` 16 cycles after the last accepted byte and `byte_cnt` = 0. With the macro undefined, expect `byte_cnt` to stay at 2.
- Reset mid-block: assert `rst_n` = 0 asynchronously after 5 bytes. Expect all outputs to return to their reset values immediately.

Source files
------------

// File: rtl/rx_block_packer.sv
// Packs good UART bytes MSB-first into BLOCK_BYTES-wide blocks and offers them over valid/ready.
// Optional inter-byte timeout is compiled in with the PACKER_TIMEOUT_EN macro.
module rx_block_packer #(
    parameter int BLOCK_BYTES    = 8,
    parameter int TIMEOUT_CYCLES = 300000,
    localparam int CW            = $clog2(BLOCK_BYTES + 1),
    localparam int DW            = 8 * BLOCK_BYTES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          done,
    input  logic          valid,
    output logic [DW-1:0] blk_data,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [CW-1:0] byte_cnt,
    output logic          err,
    output logic          overrun,
    output logic [1:0]    dbg_state_o
);

    // Handshake: blk_data is offered while blk_valid is high and is consumed on
    // any rising clk edge where blk_valid && blk_ready; blk_valid and blk_data
    // do not change while the block waits for blk_ready.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blk_valid_q, blk_valid_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;

    logic          good_byte;
    logic          bad_byte;
    logic [DW-1:0] shifted;

    assign good_byte = done && valid;
    assign bad_byte  = done && !valid;
    assign shifted   = {shreg_q[DW-9:0], rx_data};

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expired;

    assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        overrun_d = 1'b0;
`ifdef PACKER_TIMEOUT_EN
        tmo_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A bad frame with no partial block has nothing to discard.
                if (good_byte) begin
                    shreg_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (good_byte) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
                        state_d = ST_HOLD;
                    end
                end else if (bad_byte) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
`ifdef PACKER_TIMEOUT_EN
                end else if (tmo_expired) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`endif
                end
            end
            ST_HOLD: begin
                if (blk_ready) begin
                    // A byte arriving with the handshake starts the next block.
                    if (good_byte) begin
                        shreg_d = shifted;
                        cnt_d   = CW'(1);
                        state_d = ST_COLLECT;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (good_byte) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        blk_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            blk_valid_q <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            blk_valid_q <= blk_valid_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef PACKER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign blk_data    = shreg_q;
    assign blk_valid   = blk_valid_q;
    assign byte_cnt    = cnt_q;
    assign err         = err_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rx_block_packer.sv
// Directed and randomized bench for rx_block_packer against a byte-queue reference model.
module tb_rx_block_packer;

  localparam int BB   = 8;
  localparam int TMO  = 16;
  localparam int CW   = $clog2(BB + 1);
`ifdef PACKER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            done;
  logic            valid;
  logic [8*BB-1:0] blk_data;
  logic            blk_valid;
  logic            blk_ready;
  logic [CW-1:0]   byte_cnt;
  logic            err;
  logic            overrun;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model: bytes of the block being built, held flag, idle counter
  logic [7:0]      mq[$];
  logic [63:0]     exp_q[$];
  bit              m_held;
  bit              m_err;
  bit              m_ovr;
  int              m_idle;

  rx_block_packer #(.BLOCK_BYTES(BB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .done(done), .valid(valid),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .byte_cnt(byte_cnt), .err(err), .overrun(overrun), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_q();
    logic [63:0] v = '0;
    foreach (mq[i]) v = (v << 8) | 64'(mq[i]);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_held = 0; m_err = 0; m_ovr = 0; m_idle = 0;
  endtask

  // advance the model on the current inputs, then clock the DUT and compare
  task automatic step();
    logic [63:0] got;
    m_err = 0;
    m_ovr = 0;
    if (blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_block", 64'(blk_valid), 64'd0);
      end else begin
        got = exp_q.pop_front();
        check("sb_block", 64'(blk_data), got);
      end
    end
    if (m_held) begin
      if (blk_ready) begin
        m_held = 0;
        mq.delete();
        m_idle = 0;
        if (done && valid) mq.push_back(rx_data);
      end else if (done && valid) begin
        m_ovr = 1;
      end
    end else if (done && valid) begin
      mq.push_back(rx_data);
      m_idle = 0;
      if (mq.size() == BB) begin
        m_held = 1;
        exp_q.push_back(pack_q());
      end
    end else if (done && !valid) begin
      if (mq.size() > 0) m_err = 1;
      mq.delete();
      m_idle = 0;
    end else if (TMO_EN && mq.size() > 0) begin
      if (m_idle == TMO - 1) begin
        mq.delete();
        m_err  = 1;
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    @(posedge clk);
    #1;
    check("blk_valid", 64'(blk_valid), 64'(m_held));
    check("byte_cnt", 64'(byte_cnt), 64'(mq.size()));
    check("err", 64'(err), 64'(m_err));
    check("overrun", 64'(overrun), 64'(m_ovr));
    if (m_held) check("blk_data_held", 64'(blk_data), pack_q());
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic v);
    rx_data = b;
    done    = 1'b1;
    valid   = v;
    step();
    done    = 1'b0;
    valid   = 1'b0;
    rx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_data"}, 64'(blk_data), 64'd0);
    check({tag, "_blk_valid"}, 64'(blk_valid), 64'd0);
    check({tag, "_byte_cnt"}, 64'(byte_cnt), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    logic [63:0] snap;
    rst_n = 1'b0; rx_data = 8'h00; done = 1'b0; valid = 1'b0; blk_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // normal block with consumer always ready
    blk_ready = 1'b1;
    for (int i = 1; i <= BB; i++) send_byte(8'(i), 1'b1);
    check("normal_data", 64'(blk_data), 64'h0102030405060708);
    check("normal_valid", 64'(blk_valid), 64'd1);
    step();
    check("normal_valid_drop", 64'(blk_valid), 64'd0);
    check("normal_cnt_zero", 64'(byte_cnt), 64'd0);

    // stall: byte dropped while held
    blk_ready = 1'b0;
    for (int i = 0; i < BB; i++) send_byte(8'(8'h10 + i), 1'b1);
    snap = 64'(blk_data);
    send_byte(8'hAA, 1'b1);
    check("stall_overrun", 64'(overrun), 64'd1);
    check("stall_data_stable", 64'(blk_data), snap);
    step();
    check("stall_overrun_once", 64'(overrun), 64'd0);
    send_byte(8'hBB, 1'b0);
    check("stall_bad_silent", 64'(err), 64'd0);
    blk_ready = 1'b1;
    step();
    check("stall_release_cnt", 64'(byte_cnt), 64'd0);

    // handshake and new byte in the same cycle
    blk_ready = 1'b0;
    for (int i = 0; i < BB; i++) send_byte(8'(8'h20 + i), 1'b1);
    blk_ready = 1'b1;
    send_byte(8'h55, 1'b1);
    check("same_cycle_valid", 64'(blk_valid), 64'd0);
    check("same_cycle_cnt", 64'(byte_cnt), 64'd1);
    check("same_cycle_low_byte", 64'(blk_data[7:0]), 64'h55);
    for (int i = 1; i < BB; i++) send_byte(8'(8'h55 + i), 1'b1);
    check("same_cycle_block", 64'(blk_data), 64'h55565758595A5B5C);
    step();

    // bad frame discards partial block
    for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i), 1'b1);
    send_byte(8'hEE, 1'b0);
    check("bad_err", 64'(err), 64'd1);
    check("bad_cnt", 64'(byte_cnt), 64'd0);
    step();
    check("bad_err_once", 64'(err), 64'd0);
    for (int i = 0; i < BB; i++) send_byte(8'(8'hC0 + i), 1'b1);
    check("bad_then_block", 64'(blk_data), 64'hC0C1C2C3C4C5C6C7);
    step();

    // inter-byte timeout
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    if (TMO_EN) begin
      idle(TMO - 1);
      check("tmo_not_yet", 64'(err), 64'd0);
      check("tmo_cnt_before", 64'(byte_cnt), 64'd2);
      idle(1);
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_cnt_zero", 64'(byte_cnt), 64'd0);
    end else begin
      idle(TMO + 8);
      check("no_tmo_cnt", 64'(byte_cnt), 64'd2);
      send_byte(8'h00, 1'b0);
    end

    // asynchronous reset mid-block
    for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      blk_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
      end else begin
        step();
      end
    end
    blk_ready = 1'b1;
    idle(3);
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
